// File: rtl/alu_muldiv.sv
// RV32M-style multiply/divide unit: single-cycle multiply state, iterative
// restoring divider, and fast paths for divide-by-zero and signed overflow.
module alu_muldiv #(
  parameter int M = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [2:0]   FUN,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [M-1:0] RESULT
);

  localparam int KW = $clog2(M) + 1;
  localparam logic [M-1:0] MIN_NEG  = {1'b1, {(M-1){1'b0}}};
  localparam logic [M-1:0] ALL_ONES = {M{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   a_q, a_d;
  logic [M-1:0]   b_q, b_d;
  logic [2:0]     fun_q, fun_d;
  logic [M-1:0]   quo_q, quo_d;
  logic [M-1:0]   rem_q, rem_d;
  logic [M-1:0]   dvs_q, dvs_d;
  logic [M-1:0]   result_q, result_d;
  logic [KW-1:0]  k_q, k_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // Request-side decode, evaluated on the raw inputs at acceptance
  logic           accept;
  logic           in_signed;
  logic [M-1:0]   a_mag_in;
  logic [M-1:0]   b_mag_in;
  logic           fast_in;

  assign accept    = START && ((state_q == S_IDLE) || (state_q == S_FIN));
  assign in_signed = ~FUN[0];
  assign a_mag_in  = (in_signed && A[M-1]) ? -A : A;
  assign b_mag_in  = (in_signed && B[M-1]) ? -B : B;
  assign fast_in   = (B == '0) || (in_signed && (A == MIN_NEG) && (B == ALL_ONES));

  // Multiply: sign-extend to 2M bits so one unsigned product covers all variants
  logic           a_sgn, b_sgn;
  logic [2*M-1:0] a_ext, b_ext, prod;
  logic [M-1:0]   mul_res;
  logic [M-1:0]   fast_res;

  assign a_sgn   = (fun_q[1:0] == 2'b01) || (fun_q[1:0] == 2'b10);
  assign b_sgn   = (fun_q[1:0] == 2'b01);
  assign a_ext   = {{M{a_sgn & a_q[M-1]}}, a_q};
  assign b_ext   = {{M{b_sgn & b_q[M-1]}}, b_q};
  assign prod    = a_ext * b_ext;
  assign mul_res = (fun_q[1:0] == 2'b00) ? prod[M-1:0] : prod[2*M-1:M];

  // Only divide-by-zero and signed overflow reach the multiply state as divides
  assign fast_res = (b_q == '0) ? (fun_q[1] ? a_q : ALL_ONES)
                                : (fun_q[1] ? '0  : MIN_NEG);

  // One restoring step
  logic [M:0]     shifted;
  logic           ge;
  logic [M-1:0]   rem_step, quo_step;
  logic           q_neg, r_neg;
  logic [M-1:0]   q_fix, r_fix, div_res;

  assign shifted  = {rem_q, quo_q[M-1]};
  assign ge       = shifted >= {1'b0, dvs_q};
  assign rem_step = ge ? (shifted[M-1:0] - dvs_q) : shifted[M-1:0];
  assign quo_step = {quo_q[M-2:0], ge};

  assign q_neg    = ~fun_q[0] & (a_q[M-1] ^ b_q[M-1]);
  assign r_neg    = ~fun_q[0] & a_q[M-1];
  assign q_fix    = q_neg ? -quo_step : quo_step;
  assign r_fix    = r_neg ? -rem_step : rem_step;
  assign div_res  = fun_q[1] ? r_fix : q_fix;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    fun_d    = fun_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    k_d      = k_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (accept) begin
          a_d   = A;
          b_d   = B;
          fun_d = FUN;
          quo_d = a_mag_in;
          rem_d = '0;
          dvs_d = b_mag_in;
          k_d   = '0;
          state_d = (!FUN[2] || fast_in) ? S_MUL : S_DIV;
        end
      end
      S_MUL: begin
        result_d = fun_q[2] ? fast_res : mul_res;
        state_d  = S_FIN;
      end
      S_DIV: begin
        quo_d = quo_step;
        rem_d = rem_step;
        k_d   = k_q + 1'b1;
        if (k_q == KW'(M - 1)) begin
          result_d = div_res;
          state_d  = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      fun_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fun_q    <= fun_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv (M=32): results, DONE latency,
// back-to-back issue, dropped STARTs and reset abort.
module tb_alu_muldiv;

  localparam int M = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [2:0]   FUN;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [M-1:0] RESULT;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_muldiv #(.M(M)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .FUN    (FUN),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle n is observed 1 time unit after edge n-1; edge 0 accepts START.
  task automatic run_op(input string tag, input logic [2:0] fun, input logic [M-1:0] a,
                        input logic [M-1:0] b, input logic [M-1:0] exp, input int exp_cyc,
                        input bit hold);
    int cyc;
    @(negedge CLK);
    START = 1'b1;
    FUN   = fun;
    A     = a;
    B     = b;
    @(posedge CLK);
    #1;
    cyc   = 1;
    START = hold;
    if (hold) A = $urandom;
    check_eq({tag, "_busy1"}, 64'(BUSY), 64'd1);
    while (!DONE && cyc < 100) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (hold && !DONE) A = $urandom;
    end
    START = 1'b0;
    check_eq({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
    check_eq({tag, "_result"}, 64'(RESULT), 64'(exp));
    check_eq({tag, "_busy_done"}, 64'(BUSY), 64'd0);
    $display("op %s fun=%0d a=%h b=%h result=%h done_cycle=%0d", tag, fun, a, b, RESULT, cyc);
  endtask

  initial begin
    int cyc;
    int dones;
    RST   = 1'b1;
    START = 1'b1;
    FUN   = 3'b000;
    A     = 32'd5;
    B     = 32'd6;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_busy", 64'(BUSY), 64'd0);
    check_eq("rst_done", 64'(DONE), 64'd0);
    check_eq("rst_result", 64'(RESULT), 64'd0);
    @(negedge CLK);
    START = 1'b0;
    RST   = 1'b0;
    repeat (2) @(posedge CLK);

    run_op("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2,  1'b0);
    run_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2,  1'b0);
    run_op("mulh",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2,  1'b0);
    run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  1'b0);
    run_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
    run_op("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
    run_op("divu_f9_2",3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33, 1'b0);
    run_op("div_7_m2", 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1'b0);
    run_op("rem_7_m2", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 1'b0);
    repeat (2) @(posedge CLK);
    run_op("divu_z",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2,  1'b0);
    run_op("remu_z",   3'b111, 32'd5,        32'd0,        32'd5,        2,  1'b0);
    run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  1'b0);
    run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2,  1'b0);
    repeat (2) @(posedge CLK);

    // START held and A scrambled while busy, then REM issued in the DONE cycle
    run_op("div_hold", 3'b100, 32'd100,      32'd7,        32'd14,       33, 1'b1);
    run_op("rem_b2b",  3'b110, 32'd100,      32'd7,        32'd2,        33, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check_eq("idle_after_b2b_busy", 64'(BUSY), 64'd0);
    check_eq("idle_after_b2b_result", 64'(RESULT), 64'd2);

    // Reset at cycle 10 of a divide
    @(negedge CLK);
    START = 1'b1;
    FUN   = 3'b100;
    A     = 32'd1000;
    B     = 32'd3;
    @(posedge CLK);
    #1;
    cyc   = 1;
    START = 1'b0;
    while (cyc < 10) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    check_eq("abort_busy_before", 64'(BUSY), 64'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_eq("abort_busy", 64'(BUSY), 64'd0);
    check_eq("abort_result", 64'(RESULT), 64'd0);
    RST   = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (DONE) dones++;
    end
    check_eq("abort_no_done", 64'(dones), 64'd0);
    $display("op abort fun=4 a=%h b=%h dones=%0d", 32'd1000, 32'd3, dones);
    run_op("mul_3_4",  3'b000, 32'd3,        32'd4,        32'd12,       2,  1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Multi-cycle multiply/divide unit implementing the eight RV32M operations, parametrised in datapath width. It sits beside the single-cycle ALU in the execute stage. The pipeline hands it operands with a START pulse and stalls on BUSY until the one-cycle DONE pulse. Multiplies are fixed-latency; divides use an iterative restoring divider with fast paths for divide-by-zero and signed overflow.

## Interface
- M, default 32: operand and result width; legal values are M ≥ 4, even.
- CLK  in  1  rising-edge clock; the block's only clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request. Sampled on a rising edge when BUSY=0.
- FUN  in  3  operation, RISC-V funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- A  in  M  rs1 / dividend.
- B  in  M  rs2 / divisor.
- BUSY  out  1  operation in flight; START is ignored while high.
- DONE  out  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  out  M  result. Holds its value until the next DONE.

## Operation
- States:
  - IDLE: BUSY=0.
  - MUL: BUSY=1.
  - DIV: BUSY=1, iterate counter k.
  - FIN: DONE=1, BUSY=0.
- Acceptance: START=1 with BUSY=0 in IDLE or FIN latches A, B and FUN into internal registers. Later changes on the inputs have no effect.
- State transitions from IDLE or FIN on acceptance:
  - FUN[2]=0 → MUL.
  - FUN[2]=1 with B=0 → MUL (fast path).
  - Signed DIV/REM with A=2^(M-1) and B=all-ones → MUL (fast path).
  - Any other divide → DIV with k=0.
- MUL state:
  - Forms the 2M-bit product.
  - MULH: signed × signed.
  - MULHSU: signed A × unsigned B.
  - MULHU and MUL: unsigned × unsigned.
  - Writes RESULT, then goes to FIN.
  - MUL returns product[M-1:0]; the MULH variants return product[2M-1:M].
- Divide fast paths (taken from MUL state):
  - B=0: DIV/DIVU return all-ones; REM/REMU return A.
  - Signed overflow: DIV returns 2^(M-1); REM returns 0.
- DIV state:
  - Signed ops take the magnitudes |A| and |B|; unsigned ops use the raw values.
  - Each cycle performs one restoring step: shift the remainder left and bring in the next dividend MSB; subtract the divisor if the result is ≥0 and set the quotient bit.
  - k counts 0..M-1 in a counter of width $clog2(M)+1. At k=M-1, RESULT is written and the state goes to FIN.
- Sign fix-up for signed ops:
  - The quotient is negated when the signs of A and B differ.
  - The remainder takes the sign of A.
  - Unsigned ops apply no fix-up.
- FIN state:
  - DONE=1 for exactly one cycle.
  - Returns to IDLE, or accepts a new START (back-to-back issue).
- Arithmetic: all results are modulo 2^M. No exceptions or flags are produced.

## Timing
- Cycle 0 is the edge at which START is accepted.
- Done cycles:
  - MUL group and both fast paths: DONE in cycle 2.
  - Iterative divide: DONE in cycle M+1 (33 for M=32).
- BUSY is high in cycles 1 .. DONE−1 and low in the DONE cycle.
- Back-to-back: a START accepted in the DONE cycle becomes the next operation's cycle 0.
- START while BUSY=1 is dropped; it is neither queued nor does it alter the operation in flight.
- RESULT updates on the edge that enters FIN and is otherwise stable.
- Reset values (on the edge with RST=1): state IDLE, BUSY=0, DONE=0, RESULT=0, k=0, internal operand registers 0.
- RST during MUL or DIV aborts the operation. The following cycles show BUSY=0, and no DONE is issued for the aborted operation.
- RST wins over a simultaneous START.

## Test plan
- MUL, A=7, B=0xFFFFFFFD (M=32), START at cycle 0 → BUSY=1 in cycle 1; DONE=1 with RESULT=0xFFFFFFEB in cycle 2.
- A=B=0xFFFFFFFF under each high-half op:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- A=0xFFFFFFF9 (−7), B=2:
  - DIV → 0xFFFFFFFD, with DONE exactly in cycle 33.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
- Fast paths, each with DONE in cycle 2:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Busy and back-to-back:
  - DIV 100/7 with START held high and A changed during cycles 1–32 → RESULT=14 at cycle 33, with no extra operations.
  - REM 100/7 issued in the DONE cycle → RESULT=2 at cycle 33 after its own acceptance.
- RST=1 at cycle 10 of a DIV → BUSY=0 and RESULT=0 from cycle 11 on, and DONE never pulses. A new MUL 3×4 afterwards → 12 at its cycle 2.
